fir_sequencer: RTL and testbench

FIR_SEQUENCER -- requirements
Module: fir_sequencer

---
 rtl/fir_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fir_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sequencer.sv
// fir_sequencer
// Control sequencer for a time-multiplexed FIR filter. For every accepted
// sample it writes the sample into a circular delay line, then walks all
// TAPS coefficients against the delay line (newest sample first), waits for
// the MAC pipeline to drain and pulses valid_out. A clear request zeroes the
// whole delay line instead.
//
// Ports
//   clock       : single clock, rising edge
//   reset       : synchronous, active-high
//   valid_in    : a new input sample is present
//   clear       : request to zero the delay line (wins over valid_in)
//   ready_in    : high only while idle; a sample or clear is taken then
//   rom_address : coefficient index
//   ram_address : delay-line address
//   we          : delay-line write enable
//   zero_wr     : datapath writes 0 instead of the sample
//   en          : MAC accumulate enable
//   mac_init    : MAC loads the product instead of accumulating
//   valid_out   : one-cycle pulse, filter result valid
//
// Every output is a register, so no input reaches an output combinationally.
module fir_sequencer #(
    parameter int TAPS    = 8,
    parameter int ADDR_W  = 3,
    parameter int MAC_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              clear,
    output logic              ready_in,
    output logic [ADDR_W-1:0] rom_address,
    output logic [ADDR_W-1:0] ram_address,
    output logic              we,
    output logic              zero_wr,
    output logic              en,
    output logic              mac_init,
    output logic              valid_out
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RUN   = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] CLR   = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(TAPS - 1);
    // DRAIN is never entered when MAC_LAT is 0, so the clamp only keeps
    // the constant legal.
    localparam logic [2:0]        LAST_DRAIN = 3'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    logic [2:0]        state;
    logic [ADDR_W-1:0] k;
    logic [2:0]        d;
    logic [ADDR_W-1:0] wp;

    // Modulo-TAPS step helpers; explicit compare keeps the wrap correct
    // when TAPS is not a power of two.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_TAP) ? '0 : a + ADDR_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] wrap_dec(input logic [ADDR_W-1:0] a);
        return (a == '0) ? LAST_TAP : a - ADDR_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            k           <= '0;
            d           <= '0;
            wp          <= '0;
            ready_in    <= 1'b1;
            rom_address <= '0;
            ram_address <= '0;
            we          <= 1'b0;
            zero_wr     <= 1'b0;
            en          <= 1'b0;
            mac_init    <= 1'b0;
            valid_out   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below; addresses
            // simply hold when not assigned.
            we        <= 1'b0;
            zero_wr   <= 1'b0;
            en        <= 1'b0;
            mac_init  <= 1'b0;
            valid_out <= 1'b0;

            case (state)
                IDLE: begin
                    if (clear) begin
                        state       <= CLR;
                        k           <= '0;
                        ready_in    <= 1'b0;
                        we          <= 1'b1;
                        zero_wr     <= 1'b1;
                        ram_address <= '0;
                    end else if (valid_in) begin
                        // Tap 0: write the new sample and multiply it by
                        // coefficient 0 in the same cycle.
                        state       <= RUN;
                        k           <= '0;
                        ready_in    <= 1'b0;
                        we          <= 1'b1;
                        en          <= 1'b1;
                        mac_init    <= 1'b1;
                        rom_address <= '0;
                        ram_address <= wp;
                    end
                end

                RUN: begin
                    if (k == LAST_TAP) begin
                        if (MAC_LAT == 0) begin
                            state     <= DONE;
                            valid_out <= 1'b1;
                        end else begin
                            state <= DRAIN;
                            d     <= '0;
                        end
                    end else begin
                        // ram_address walks back from wp, i.e. (wp-k) mod TAPS.
                        k           <= k + ADDR_W'(1);
                        en          <= 1'b1;
                        rom_address <= k + ADDR_W'(1);
                        ram_address <= wrap_dec(ram_address);
                    end
                end

                DRAIN: begin
                    if (d == LAST_DRAIN) begin
                        state     <= DONE;
                        valid_out <= 1'b1;
                    end else begin
                        d <= d + 3'd1;
                    end
                end

                DONE: begin
                    wp       <= wrap_inc(wp);
                    state    <= IDLE;
                    ready_in <= 1'b1;
                end

                CLR: begin
                    if (k == LAST_TAP) begin
                        wp       <= '0;
                        state    <= IDLE;
                        ready_in <= 1'b1;
                    end else begin
                        k           <= k + ADDR_W'(1);
                        we          <= 1'b1;
                        zero_wr     <= 1'b1;
                        ram_address <= k + ADDR_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    ready_in <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// Testbench for fir_sequencer: directed table, directed corner sequences and
// random stimulus, all checked against a schedule-based reference model.
module tb_fir_sequencer;

    localparam int T1 = 8;
    localparam int L1 = 1;
    localparam int N  = 4096;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, valid_in, clear;
    logic       ready_in, we, zero_wr, en, mac_init, valid_out;
    logic [2:0] rom_address, ram_address;

    logic       rst2, v2, c2;
    logic       rdy2, we2, zr2, en2, mi2, vo2;
    logic [2:0] rom2, ram2;

    fir_sequencer #(.TAPS(8), .ADDR_W(3), .MAC_LAT(1)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .clear(clear),
        .ready_in(ready_in), .rom_address(rom_address), .ram_address(ram_address),
        .we(we), .zero_wr(zero_wr), .en(en), .mac_init(mac_init), .valid_out(valid_out)
    );

    fir_sequencer #(.TAPS(5), .ADDR_W(3), .MAC_LAT(0)) dut5 (
        .clock(clock), .reset(rst2), .valid_in(v2), .clear(c2),
        .ready_in(rdy2), .rom_address(rom2), .ram_address(ram2),
        .we(we2), .zero_wr(zr2), .en(en2), .mac_init(mi2), .valid_out(vo2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each acceptance or clear writes its whole future
    // output schedule (indexed by edge number) into these arrays.
    bit       x_we[N], x_zero[N], x_en[N], x_init[N], x_vout[N];
    bit       x_romdef[N], x_ramdef[N];
    bit [2:0] x_rom[N], x_ram[N];
    int       idle_edge = 1 << 30;
    int       m_wp = 0;
    int       e = 0;
    bit [2:0] cur_rom = 0, cur_ram = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input bit c);
        if (r) begin
            for (int j = e; j < N; j++) begin
                x_we[j] = 0; x_zero[j] = 0; x_en[j] = 0; x_init[j] = 0;
                x_vout[j] = 0; x_romdef[j] = 0; x_ramdef[j] = 0;
            end
            x_romdef[e] = 1; x_rom[e] = 0;
            x_ramdef[e] = 1; x_ram[e] = 0;
            idle_edge = e;
            m_wp = 0;
        end else if (e - 1 >= idle_edge) begin
            if (c) begin
                for (int i = 0; i < T1; i++) begin
                    x_we[e+i] = 1; x_zero[e+i] = 1;
                    x_ramdef[e+i] = 1; x_ram[e+i] = 3'(i);
                end
                idle_edge = e + T1;
                m_wp = 0;
            end else if (v) begin
                for (int i = 0; i < T1; i++) begin
                    x_en[e+i] = 1;
                    x_romdef[e+i] = 1; x_rom[e+i] = 3'(i);
                    x_ramdef[e+i] = 1; x_ram[e+i] = 3'((m_wp - i + T1) % T1);
                end
                x_we[e] = 1;
                x_init[e] = 1;
                x_vout[e + T1 + L1] = 1;
                idle_edge = e + T1 + L1 + 1;
                m_wp = (m_wp + 1) % T1;
            end
        end
    endtask

    task automatic check_model();
        bit [11:0] exp_v, act_v;
        if (x_romdef[e]) cur_rom = x_rom[e];
        if (x_ramdef[e]) cur_ram = x_ram[e];
        exp_v = {(e >= idle_edge), x_we[e], x_zero[e], x_en[e], x_init[e], x_vout[e], cur_rom, cur_ram};
        act_v = {ready_in, we, zero_wr, en, mac_init, valid_out, rom_address, ram_address};
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL model edge %0d: got %b expected %b (rdy,we,zero,en,init,vout,rom,ram)",
                     e, act_v, exp_v);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit c);
        reset = r; valid_in = v; clear = c;
        @(posedge clock);
        model_edge(r, v, c);
        #1;
        check_model();
        e++;
    endtask

    typedef struct {
        bit       v;
        bit [2:0] rom;
        bit [2:0] ram;
        bit       we;
        bit       en;
        bit       init;
        bit       vout;
        bit       rdy;
    } vec_t;

    vec_t tbl[12];
    int   acc_e[$];
    int   wr_a[$];
    int   en_a[$];
    int   wq2[$];
    int   we2_e[$];
    int   eq2[$];
    int   cnt_v, cnt_en, cnt_we;

    initial begin
        reset = 1; valid_in = 0; clear = 0;
        rst2 = 1; v2 = 0; c2 = 0;

        // Single-sample trace for TAPS=8, MAC_LAT=1 (row i = outputs after edge i).
        tbl[0] = '{1, 0, 0, 1, 1, 1, 0, 0};
        for (int i = 1; i < 8; i++) tbl[i] = '{0, 3'(i), 3'(8 - i), 0, 1, 0, 0, 0};
        tbl[8]  = '{0, 7, 1, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 7, 1, 0, 0, 0, 1, 0};
        tbl[10] = '{0, 7, 1, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 7, 1, 0, 0, 0, 0, 1};

        step(1, 0, 0);
        step(1, 0, 0);
        rst2 = 0;
        chk("reset_ready", ready_in, 1);
        chk("reset_strobes", {we, zero_wr, en, mac_init, valid_out}, 0);
        chk("reset_addr", {rom_address, ram_address}, 0);

        for (int i = 0; i < 12; i++) begin
            step(0, tbl[i].v, 0);
            chk($sformatf("tbl%0d", i),
                {rom_address, ram_address, we, en, mac_init, valid_out, ready_in},
                {tbl[i].rom, tbl[i].ram, tbl[i].we, tbl[i].en, tbl[i].init, tbl[i].vout, tbl[i].rdy});
        end

        // Back-to-back samples with valid_in held high.
        step(1, 0, 0);
        cnt_v = 0;
        for (int s = 0; s < 59; s++) begin
            step(0, s < 44, 0);
            if (mac_init) begin acc_e.push_back(e - 1); wr_a.push_back(ram_address); end
            if (valid_out) cnt_v++;
        end
        chk("b2b_accepts", acc_e.size(), 4);
        chk("b2b_vouts", cnt_v, 4);
        if (acc_e.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("b2b_wp%0d", i), wr_a[i], i);
            for (int i = 1; i < 4; i++) chk($sformatf("b2b_gap%0d", i), acc_e[i] - acc_e[i-1], 11);
        end

        // valid_in and clear pulsed during RUN (wp is 4 here).
        en_a.delete(); cnt_v = 0; cnt_we = 0;
        step(0, 1, 0);
        en_a.push_back(ram_address); cnt_we += we;
        for (int i = 1; i < 14; i++) begin
            step(0, 1'(i % 2), 1'((i + 1) % 2 == 0 || i < 9));
            if (en) en_a.push_back(ram_address);
            if (we) cnt_we++;
            if (valid_out) cnt_v++;
            if (ready_in) break;
        end
        chk("run_ignore_taps", en_a.size(), 8);
        if (en_a.size() == 8)
            for (int i = 0; i < 8; i++) chk($sformatf("run_ignore_ram%0d", i), en_a[i], (4 - i + 8) % 8);
        chk("run_ignore_vout", cnt_v, 1);
        chk("run_ignore_we", cnt_we, 1);

        // clear and valid_in together in IDLE (wp is 5 here).
        wr_a.delete(); cnt_en = 0; cnt_v = 0;
        step(0, 1, 1);
        if (we && zero_wr) wr_a.push_back(ram_address);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            if (we && zero_wr) wr_a.push_back(ram_address);
            if (en) cnt_en++;
            if (valid_out) cnt_v++;
        end
        chk("clr_writes", wr_a.size(), 8);
        if (wr_a.size() == 8)
            for (int i = 0; i < 8; i++) chk($sformatf("clr_addr%0d", i), wr_a[i], i);
        chk("clr_en", cnt_en, 0);
        chk("clr_vout", cnt_v, 0);
        step(0, 1, 0);
        chk("clr_then_wp0", {we, ram_address}, {1'b1, 3'd0});
        for (int i = 0; i < 10; i++) step(0, 0, 0);

        // Reset at RUN tap k=3 aborts the sample.
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        chk("abort_at_k3", rom_address, 3);
        step(1, 0, 0);
        chk("abort_ready", ready_in, 1);
        chk("abort_outputs", {we, zero_wr, en, mac_init, valid_out, rom_address, ram_address}, 0);
        cnt_v = 0;
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0);
            if (valid_out) cnt_v++;
        end
        chk("abort_no_vout", cnt_v, 0);

        // TAPS=5, MAC_LAT=0: six samples, checking the wrap from wp=4.
        v2 = 1;
        for (int i = 0; i < 60 && wq2.size() < 6; i++) begin
            step(0, 0, 0);
            if (we2) begin wq2.push_back(ram2); we2_e.push_back(e - 1); end
            if (en2) eq2.push_back(ram2);
        end
        v2 = 0;
        chk("t5_samples", wq2.size(), 6);
        if (wq2.size() == 6) begin
            chk("t5_wr4", wq2[4], 4);
            chk("t5_wr5", wq2[5], 0);
            chk("t5_period", we2_e[5] - we2_e[4], 7);
            for (int i = 0; i < 5; i++) chk($sformatf("t5_ram%0d", i), eq2[20 + i], 4 - i);
        end

        // Random stimulus against the model.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
